// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave backed by a byte-wide memory; one transaction in flight at a time.
// Optional read-only low region enabled by defining AXIL_SLAVE_RO_REGION_EN.
module axi_lite_slave_mem #(
  parameter int unsigned MEM_DEPTH = 4096,
  parameter int unsigned RO_LIMIT = 16,
  localparam int unsigned ADDR_WIDTH = 12,
  localparam int unsigned DATA_WIDTH = 8,
  localparam int unsigned STRB_WIDTH = 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef AXIL_SLAVE_RO_REGION_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WADDR,
    WDATA,
    WRESP
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  last_grant_wr;
  logic                  last_grant_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  ar_hs_c;
  logic                  aw_hs_c;
  logic                  w_hs_c;
  logic                  rd_decerr_c;
  logic                  wr_decerr_c;
  logic                  ro_hit_c;
  logic                  mem_we_c;
  logic [1:0]            bresp_c;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Address decode and write-permission checks
  assign rd_decerr_c = 32'(araddr) >= MEM_DEPTH;
  assign wr_decerr_c = 32'(addr_q) >= MEM_DEPTH;
  assign ro_hit_c    = RO_EN && (32'(addr_q) < RO_LIMIT);
  assign mem_we_c    = w_hs_c && wstrb[0] && !wr_decerr_c && !ro_hit_c && !areset;

  // Write response: decode error dominates; a strobe-less beat is a harmless no-op
  always_comb begin
    bresp_c = RESP_OKAY;
    if (wr_decerr_c) begin
      bresp_c = RESP_DECERR;
    end else if (wstrb[0] && ro_hit_c) begin
      bresp_c = RESP_SLVERR;
    end
  end

  // Next-state logic; contention alternates, starting with read after reset
  always_comb begin
    next_state      = state;
    last_grant_wr_d = last_grant_wr;
    ar_hs_c         = 1'b0;
    aw_hs_c         = 1'b0;
    w_hs_c          = 1'b0;
    case (state)
      IDLE: begin
        if (arvalid && awvalid) begin
          next_state      = last_grant_wr ? RADDR : WADDR;
          last_grant_wr_d = ~last_grant_wr;
        end else if (arvalid) begin
          next_state = RADDR;
        end else if (awvalid) begin
          next_state = WADDR;
        end
      end
      RADDR: begin
        if (arvalid && arready) begin
          ar_hs_c    = 1'b1;
          next_state = RDATA;
        end
      end
      RDATA: begin
        if (rready) next_state = IDLE;
      end
      WADDR: begin
        if (awvalid && awready) begin
          aw_hs_c    = 1'b1;
          next_state = WDATA;
        end
      end
      WDATA: begin
        if (wvalid && wready) begin
          w_hs_c     = 1'b1;
          next_state = WRESP;
        end
      end
      WRESP: begin
        if (bready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register and Moore outputs decoded from the next state
  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      last_grant_wr <= 1'b1;
      addr_q        <= '0;
      arready       <= 1'b0;
      rvalid        <= 1'b0;
      awready       <= 1'b0;
      wready        <= 1'b0;
      bvalid        <= 1'b0;
      rdata         <= '0;
      rresp         <= RESP_OKAY;
      bresp         <= RESP_OKAY;
    end else begin
      state         <= next_state;
      last_grant_wr <= last_grant_wr_d;
      arready       <= (next_state == RADDR);
      rvalid        <= (next_state == RDATA);
      awready       <= (next_state == WADDR);
      wready        <= (next_state == WDATA);
      bvalid        <= (next_state == WRESP);
      if (aw_hs_c) addr_q <= awaddr;
      if (ar_hs_c) begin
        addr_q <= araddr;
        rdata  <= rd_decerr_c ? '0 : mem[IDX_W'(araddr)];
        rresp  <= rd_decerr_c ? RESP_DECERR : RESP_OKAY;
      end
      if (w_hs_c) bresp <= bresp_c;
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge aclk) begin
    if (mem_we_c) mem[IDX_W'(addr_q)] <= wdata;
  end

endmodule
